fetch_entry_fifo: RTL and testbench
===================================

# fetch_entry_fifo

Decoupling FIFO between the frontend instruction realigner and the decode stage, single issue port. Absorbs fetch bursts while decode or issue is stalled. Presents one registered `fetch_entry_t` to decode with a valid/ready handshake. Supports a one-cycle flush for mispredicts and exceptions.

## Interface
- `CVA6Cfg`, default `config_pkg::cva6_cfg_empty`: core configuration. Carried only for type consistency.
- `fetch_entry_t`, default `logic`: fetch entry struct (instruction, address, branch_predict, ex).
- `Depth`, default 4: number of entries. Must be a power of two and ≥2.
- `clk_i`  in  1  core clock.
- `rst_i`  in  1  reset. Synchronous, active-high.
- `flush_i`  in  1  discard all stored entries.
- `fetch_entry_i`  in  $bits(fetch_entry_t)  entry from the frontend.
- `fetch_entry_valid_i`  in  1  frontend entry valid.
- `fetch_entry_ready_o`  out  1  FIFO can accept an entry.
- `fetch_entry_o`  out  $bits(fetch_entry_t)  head entry, driven to decode.
- `fetch_entry_valid_o`  out  1  head entry valid.
- `fetch_entry_ready_i`  in  1  decode consumes the head.
- `count_o`  out  $clog2(Depth)+1  current occupancy, for performance counters.

## Operation
- Storage:
  - `Depth` entries, read pointer `rd_q` and write pointer `wr_q`, both $clog2(Depth) bits.
  - Occupancy `cnt_q` is $clog2(Depth)+1 bits.
  - Pointers wrap naturally (power-of-two depth).
- Push: `fetch_entry_valid_i && fetch_entry_ready_o`.
  - Write `mem[wr_q]`, then increment `wr_q`.
- Pop: `fetch_entry_valid_o && fetch_entry_ready_i`.
  - Increment `rd_q`.
- Count update:
  - Push only: `cnt_q+1`.
  - Pop only: `cnt_q-1`.
  - Push and pop together: unchanged.
- Output signals:
  - `fetch_entry_ready_o = (cnt_q != Depth)`. It does not depend on `fetch_entry_ready_i`, so there is no combinational in→out path.
  - `fetch_entry_valid_o = (cnt_q != 0)`.
  - `fetch_entry_o = mem[rd_q]`.
  - `count_o = cnt_q`.
- Full with a pop in the same cycle: the push is still refused, because ready is computed from registered state.
- Empty: no fall-through. A push into an empty FIFO becomes visible at the output the next cycle.
- Flush:
  - Next-state `rd_q = wr_q = 0` and `cnt_q = 0`.
  - Any push or pop in the flush cycle is discarded.
  - Memory contents are not cleared.
- Reset:
  - Same as flush, plus all `mem` entries are cleared to `'0`.
  - Reset has priority over flush.
- Parameter check: an elaboration-time error is raised if `Depth` < 2 or is not a power of two.

## Timing
- Latency: 1 cycle from accepted push to `fetch_entry_valid_o`.
- Throughput: 1 push and 1 pop per cycle when 0 < count < Depth.
- Output values during and after reset:
  - `fetch_entry_ready_o = 1`, `fetch_entry_valid_o = 0`, `count_o = 0`, `fetch_entry_o = '0`.
  - These values hold in the first cycle after `rst_i` deasserts.
- After a flush, in the next cycle: `fetch_entry_valid_o = 0` and `fetch_entry_ready_o = 1`.
- `fetch_entry_o` is held stable while `fetch_entry_valid_o && !fetch_entry_ready_i`.
- All outputs are functions of registered state only.

## Structure
- No new package content; `fetch_entry_t` comes from the `cva6` top-level typedefs as for the other stages.
- No sub-module: pointers, counter and storage are implemented inline in a single `always_ff` with synchronous reset.

## Test plan
- Reset check: hold `rst_i` for 2 cycles, then release → `ready_o=1`, `valid_o=0`, `count_o=0`, `fetch_entry_o='0`.
- Fill then drain (Depth=4, decode ready low):
  - Push addresses 0x80000000, 0x80000004, 0x80000008, 0x8000000C → `count_o=4`, `ready_o=0`.
  - A 5th push is held off, with `ready_o` low that cycle.
  - Raise decode ready → four pops in order, then `valid_o=0`.
- Streaming: valid in and ready out held high for 100 cycles with incrementing addresses → `count_o` stays at 1 after the first cycle, one entry is delivered per cycle, and order is preserved.
- Full with simultaneous pop: `count_o=4`, frontend valid and decode ready both high → the head pops, nothing is written, and `count_o=3` in the next cycle.
- Flush with simultaneous push: `count_o=3`, `flush_i=1` and push valid in the same cycle → next cycle `count_o=0` and `valid_o=0`. The next push then appears alone at the head.
- Pointer wrap: 10 push/pop cycles with `Depth=4`, checked against a reference-model queue → the data sequence matches and `count_o` never exceeds 4.

Source files
------------

// File: rtl/config_pkg.sv
// Core configuration package.
// Only the fields this slice of the core needs are present; the FIFO takes
// the configuration so its parameter list matches the other pipeline stages.
package config_pkg;

    typedef struct packed {
        int unsigned NrIssuePorts;
        int unsigned XLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// File: rtl/fetch_entry_fifo_pkg.sv
// Helpers shared by the fetch-entry FIFO.
package fetch_entry_fifo_pkg;

    // True when v is a non-zero power of two.
    function automatic logic is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/fetch_entry_fifo.sv
// fetch_entry_fifo
//   Decoupling FIFO between the instruction realigner and decode. It absorbs
//   fetch bursts while decode is stalled and presents one registered head
//   entry with a valid/ready handshake. Flush empties it in one cycle.
//
// Ports
//   clk_i                core clock
//   rst_i                synchronous active-high reset (clears storage too)
//   flush_i              discard all stored entries
//   fetch_entry_i        entry from the frontend
//   fetch_entry_valid_i  frontend entry valid
//   fetch_entry_ready_o  FIFO can accept an entry (registered state only)
//   fetch_entry_o        head entry to decode
//   fetch_entry_valid_o  head entry valid
//   fetch_entry_ready_i  decode consumes the head
//   count_o              current occupancy
module fetch_entry_fifo
    import fetch_entry_fifo_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter type fetch_entry_t = logic,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  fetch_entry_t             fetch_entry_i,
    input  logic                     fetch_entry_valid_i,
    output logic                     fetch_entry_ready_o,
    output fetch_entry_t             fetch_entry_o,
    output logic                     fetch_entry_valid_o,
    input  logic                     fetch_entry_ready_i,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    if (Depth < 2 || !is_pow2(Depth)) begin : g_bad_depth
        $error("fetch_entry_fifo: Depth must be a power of two and >= 2");
    end

    // This FIFO feeds exactly one decode/issue lane.
    if (CVA6Cfg.NrIssuePorts > 1) begin : g_bad_issue_ports
        $error("fetch_entry_fifo: only a single issue port is supported");
    end

    fetch_entry_t            mem_q [Depth];
    logic        [PtrW-1:0]  rd_q;
    logic        [PtrW-1:0]  wr_q;
    logic        [CntW-1:0]  cnt_q;
    logic                    push;
    logic                    pop;

    // Ready and valid come straight from the registered count, so there is no
    // combinational path from fetch_entry_ready_i to fetch_entry_ready_o; a
    // full FIFO refuses a push even when the head pops in the same cycle.
    assign fetch_entry_ready_o = (cnt_q != CntW'(Depth));
    assign fetch_entry_valid_o = (cnt_q != '0);
    assign fetch_entry_o       = mem_q[rd_q];
    assign count_o             = cnt_q;

    assign push = fetch_entry_valid_i && fetch_entry_ready_o;
    assign pop  = fetch_entry_valid_o && fetch_entry_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            mem_q <= '{default: '0};
        end else if (flush_i) begin
            // Storage is left as is; only the bookkeeping is reset.
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= fetch_entry_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_entry_fifo.sv
module tb_fetch_entry_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] address;
        logic [1:0]  bp;
        logic        ex;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    ent_t          din;
    logic          vin;
    logic          rdy_out;
    ent_t          dout;
    logic          vout;
    logic          rdy_in;
    logic [CW-1:0] cnt;

    int nvec = 0;
    int nmis = 0;
    logic chk_en = 1'b0;

    ent_t mq[$];

    always #5 clk = ~clk;

    fetch_entry_fifo #(
        .CVA6Cfg       (config_pkg::cva6_cfg_empty),
        .fetch_entry_t (ent_t),
        .Depth         (DEPTH)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .flush_i             (flush),
        .fetch_entry_i       (din),
        .fetch_entry_valid_i (vin),
        .fetch_entry_ready_o (rdy_out),
        .fetch_entry_o       (dout),
        .fetch_entry_valid_o (vout),
        .fetch_entry_ready_i (rdy_in),
        .count_o             (cnt)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of accepted entries.
    always @(posedge clk) begin
        logic do_push;
        logic do_pop;
        if (rst || flush) begin
            mq.delete();
        end else begin
            do_push = vin && (mq.size() < DEPTH);
            do_pop  = rdy_in && (mq.size() > 0);
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(din);
        end
    end

    // Cycle-by-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_ready", 128'(rdy_out), 128'(mq.size() != DEPTH));
            chk("m_valid", 128'(vout), 128'(mq.size() != 0));
            chk("m_count", 128'(cnt), 128'(mq.size()));
            chk("m_count_bound", 128'(cnt <= CW'(DEPTH)), 128'(1'b1));
            if (mq.size() != 0) begin
                chk("m_head", 128'(dout), 128'(mq[0]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_din(input logic [31:0] addr, input logic [31:0] insn);
        din = '0;
        din.address = addr;
        din.instruction = insn;
    endtask

    logic [9:0] wrap_v = 10'b1101101111;
    logic [9:0] wrap_r = 10'b0110110101;

    initial begin
        rst = 1'b1; flush = 1'b0; vin = 1'b0; rdy_in = 1'b0; din = '0;

        // Reset held two cycles
        cyc();
        chk_en = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_ready", 128'(rdy_out), 128'(1'b1));
        chk("rst_valid", 128'(vout), 128'(1'b0));
        chk("rst_count", 128'(cnt), 128'(0));
        chk("rst_entry", 128'(dout), 128'(0));

        // Fill with decode stalled
        for (int i = 0; i < 4; i++) begin
            set_din(32'h8000_0000 + 32'(4 * i), 32'h0000_0013 + 32'(i));
            vin = 1'b1;
            cyc();
        end
        chk("fill_count", 128'(cnt), 128'(4));
        chk("fill_ready", 128'(rdy_out), 128'(1'b0));
        set_din(32'h8000_0010, 32'h0000_0017);
        cyc();
        vin = 1'b0;
        chk("fifth_count", 128'(cnt), 128'(4));
        chk("fifth_ready", 128'(rdy_out), 128'(1'b0));

        // Drain in order
        rdy_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 128'(vout), 128'(1'b1));
            chk("drain_addr", 128'(dout.address), 128'(32'h8000_0000 + 32'(4 * i)));
            cyc();
        end
        chk("drain_empty", 128'(vout), 128'(1'b0));
        chk("drain_count", 128'(cnt), 128'(0));
        rdy_in = 1'b0;

        // Streaming: one in, one out per cycle
        vin = 1'b1; rdy_in = 1'b1;
        for (int k = 0; k < 100; k++) begin
            set_din(32'h0000_1000 + 32'(4 * k), 32'(k));
            cyc();
            chk("stream_count", 128'(cnt), 128'(1));
            chk("stream_addr", 128'(dout.address), 128'(32'h0000_1000 + 32'(4 * k)));
        end
        vin = 1'b0;
        cyc();
        chk("stream_end", 128'(cnt), 128'(0));
        rdy_in = 1'b0;

        // Full with simultaneous pop: push refused
        vin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_din(32'h0000_2000 + 32'(4 * i), 32'(i));
            cyc();
        end
        chk("full_count", 128'(cnt), 128'(4));
        set_din(32'h0000_3000, 32'h3);
        rdy_in = 1'b1;
        cyc();
        vin = 1'b0; rdy_in = 1'b0;
        chk("fullpop_count", 128'(cnt), 128'(3));
        chk("fullpop_head", 128'(dout.address), 128'(32'h0000_2004));

        // Flush with simultaneous push
        flush = 1'b1; vin = 1'b1;
        set_din(32'h0000_4000, 32'h4);
        cyc();
        flush = 1'b0; vin = 1'b0;
        chk("flush_count", 128'(cnt), 128'(0));
        chk("flush_valid", 128'(vout), 128'(1'b0));
        chk("flush_ready", 128'(rdy_out), 128'(1'b1));
        set_din(32'h0000_5000, 32'h5);
        vin = 1'b1;
        cyc();
        vin = 1'b0;
        chk("postflush_count", 128'(cnt), 128'(1));
        chk("postflush_head", 128'(dout.address), 128'(32'h0000_5000));
        rdy_in = 1'b1;
        cyc();
        rdy_in = 1'b0;
        chk("postflush_drain", 128'(cnt), 128'(0));

        // Pointer wrap with mixed push/pop, checked by the model each cycle
        for (int k = 0; k < 10; k++) begin
            set_din(32'h0000_6000 + 32'(4 * k), 32'(100 + k));
            vin = wrap_v[k];
            rdy_in = wrap_r[k];
            cyc();
        end
        vin = 1'b0; rdy_in = 1'b1;
        repeat (6) cyc();
        chk("wrap_drained", 128'(cnt), 128'(0));
        rdy_in = 1'b0;
        cyc();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
